uart_bus_cmd_engine: RTL and testbench
======================================

Name: uart_bus_cmd_engine

Overview:
- UART-driven debug/load engine for the NES system bus.
- Sits between the host-side uart_rx/UART_TX pair and the CPU-side memory bus.
- Decodes host command bytes into single or burst reads and writes, and into CPU halt/release.
- Successor to the fixed 16-bit single-byte command decoder:
  - address width is parametrised;
  - adds burst transfers with address auto-increment;
  - adds an inter-byte timeout and an error counter.

Parameters:
ADDR_W, 16, bus address width (1..32); ADDR_BYTES = ceil(ADDR_W/8) address bytes per command, MSB first, excess upper bits ignored
RD_LAT, 2, cycles from bus_re pulse to valid bus_rdata (1..7)
TIMEOUT_CYC, 100000, idle cycles allowed between rx bytes inside a command before abort (>=16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received byte
tx_start  out  1  one-cycle strobe to UART transmitter
tx_data  out  8  byte to transmit, stable from tx_start until tx_done
tx_done  in  1  one-cycle strobe, transmitter finished byte
bus_addr  out  ADDR_W  bus address
bus_wdata  out  8  write data
bus_we  out  1  one-cycle write strobe
bus_re  out  1  one-cycle read strobe
bus_rdata  in  8  read data, valid RD_LAT cycles after bus_re
cpu_halt  out  1  1 = CPU/PPU held, bus owned by engine
busy  out  1  1 whenever state != IDLE
err_count  out  8  saturating count of protocol errors

Behaviour:
- Reset values:
  - tx_start=0, tx_data=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, busy=0, err_count=0.
  - cpu_halt=1: the CPU stays held until command 0x07.
  - Internal state IDLE, timeout counter 0.
- Commands (first byte, accepted in IDLE only):
  - 0x02 write: ADDR_BYTES address bytes, 1 data byte.
  - 0x03 read: ADDR_BYTES address bytes; 1 byte returned.
  - 0x04 burst write: address bytes, length byte L, then L+1 data bytes.
  - 0x05 burst read: address bytes, length byte L; L+1 bytes returned.
  - 0x06: cpu_halt<=1. 0x07: cpu_halt<=0. Both take effect the cycle after rx_valid; no reply.
  - Any other byte: ignored, err_count+1, stay IDLE.
- States: IDLE, ADDR, LEN, WDATA, WSTROBE, RREQ, RWAIT, TXGO, TXWAIT.
- Address capture: bytes shift into addr register MSB first; the last byte moves to LEN (bursts), WDATA (0x02) or RREQ (0x03).
- Write:
  - WSTROBE asserts bus_we for exactly 1 cycle, with bus_addr/bus_wdata valid that cycle.
  - The next cycle bus_addr increments and remaining count decrements.
  - When count exhausted -> IDLE, else -> WDATA.
- Read:
  - RREQ asserts bus_re 1 cycle, then RWAIT for RD_LAT cycles.
  - bus_rdata latched into tx_data on the RD_LAT-th cycle, then TXGO.
  - TXGO pulses tx_start 1 cycle, then TXWAIT until tx_done.
  - After tx_done: address+1 and count-1; next byte -> RREQ, done -> IDLE.
- Address arithmetic is modulo 2^ADDR_W; a burst crossing the top wraps to 0 silently.
- Commands are accepted regardless of cpu_halt. The bus is shared, so host software issues 0x06 first; the engine does not enforce this.
- rx_valid arriving in RREQ/RWAIT/TXGO/TXWAIT/WSTROBE: byte dropped, err_count+1, current transfer continues.
- Timeout:
  - In ADDR, LEN or WDATA, the counter increments each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYC aborts to IDLE with err_count+1; no bus strobe is issued.
  - The counter is cleared in all other states.
- err_count saturates at 0xFF.
- Reset mid-operation: all outputs return to reset values immediately; a partial write strobe is truncated and cpu_halt is forced to 1.

Test Plan:
- After reset, send 06, 02, 80, 10, A5 -> cpu_halt=1; exactly one bus_we cycle with bus_addr=0x8010, bus_wdata=0xA5.
- Send 03, 80, 10 with the memory model returning 0xA5 at RD_LAT=2 -> one tx_start with tx_data=0xA5; busy falls the cycle after tx_done.
- Send 04, 00, FE, 03, 11, 22, 33, 44 -> four bus_we at addresses 0x00FE, 0x00FF, 0x0100, 0x0101 with data 11, 22, 33, 44; then 05, 00, FE, 03 -> tx bytes 11, 22, 33, 44 in order.
- Send 04, FF, FF, 01, AA, BB -> writes at 0xFFFF then 0x0000 (wrap); err_count unchanged.
- Send 02, 12 then silence for TIMEOUT_CYC cycles -> no bus_we, state IDLE, err_count=1; then send 0x55 -> err_count=2.
- ADDR_W=20 build: send 02, 01, 23, 45, 7E -> bus_we at 0x12345 with data 0x7E; then send 07 -> cpu_halt=0.

Source files
------------

// File: rtl/uart_bus_cmd_engine_if.sv
// Host UART byte stream, CPU memory bus and status signals of the command engine.
// The master modport is the engine side; the slave modport is the UART/memory side.
interface uart_bus_cmd_engine_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [7:0]        bus_rdata;
  logic              cpu_halt;
  logic              busy;
  logic [7:0]        err_count;

  modport master (
    input  rx_valid, rx_data, tx_done, bus_rdata,
    output tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, cpu_halt, busy, err_count
  );

  modport slave (
    output rx_valid, rx_data, tx_done, bus_rdata,
    input  tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, cpu_halt, busy, err_count
  );
endinterface

// File: rtl/uart_bus_cmd_engine.sv
// UART command engine: decodes host bytes into single/burst bus reads and writes plus
// CPU halt/release, with an inter-byte timeout and a saturating protocol error counter.
module uart_bus_cmd_engine #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input logic                    clk,
  input logic                    rst,
  uart_bus_cmd_engine_if.master  bus
);
  localparam int unsigned AddrBytes = (ADDR_W + 7) / 8;
  localparam int unsigned TmoW      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StLen, StWdata, StWstrobe, StRreq, StRwait, StTxgo, StTxwait
  } state_e;

  state_e            state_q, state_d;
  logic              is_read_q, is_read_d;
  logic              is_burst_q, is_burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        abyte_q, abyte_d;
  logic [2:0]        lat_q, lat_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              halt_q, halt_d;
  logic [7:0]        err_q, err_d;
  logic              err_inc;

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    is_burst_d = is_burst_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    abyte_d    = abyte_q;
    lat_d      = lat_q;
    tmo_d      = '0;
    halt_d     = halt_q;
    err_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h02, 8'h03, 8'h04, 8'h05: begin
              // bit 0 selects read, bit 2 selects burst
              is_read_d  = bus.rx_data[0];
              is_burst_d = bus.rx_data[2];
              abyte_d    = '0;
              cnt_d      = '0;
              state_d    = StAddr;
            end
            8'h06:   halt_d = 1'b1;
            8'h07:   halt_d = 1'b0;
            default: err_inc = 1'b1;
          endcase
        end
      end
      StAddr: begin
        if (bus.rx_valid) begin
          addr_d = ADDR_W'({addr_q, bus.rx_data});
          if (abyte_q == 2'(AddrBytes - 1)) begin
            if (is_burst_q)     state_d = StLen;
            else if (is_read_q) state_d = StRreq;
            else                state_d = StWdata;
          end else begin
            abyte_d = abyte_q + 2'd1;
          end
        end
      end
      StLen: begin
        if (bus.rx_valid) begin
          cnt_d   = bus.rx_data;
          state_d = is_read_q ? StRreq : StWdata;
        end
      end
      StWdata: begin
        if (bus.rx_valid) begin
          wdata_d = bus.rx_data;
          state_d = StWstrobe;
        end
      end
      StWstrobe: begin
        addr_d = addr_q + 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = StWdata;
        end
      end
      StRreq: begin
        lat_d   = '0;
        state_d = StRwait;
      end
      StRwait: begin
        if (lat_q == 3'(RD_LAT - 1)) begin
          tx_data_d = bus.bus_rdata;
          state_d   = StTxgo;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StTxgo: state_d = StTxwait;
      StTxwait: begin
        if (bus.tx_done) begin
          addr_d = addr_q + 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            state_d = StRreq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q inside {StAddr, StLen, StWdata}) begin
      if (bus.rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
        err_inc = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // Bytes arriving while a bus transfer or reply is in flight are dropped.
    if (bus.rx_valid && (state_q inside {StWstrobe, StRreq, StRwait, StTxgo, StTxwait})) begin
      err_inc = 1'b1;
    end

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      is_read_q  <= 1'b0;
      is_burst_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      abyte_q    <= '0;
      lat_q      <= '0;
      tmo_q      <= '0;
      halt_q     <= 1'b1;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      is_burst_q <= is_burst_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      abyte_q    <= abyte_d;
      lat_q      <= lat_d;
      tmo_q      <= tmo_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode straight from the state so an async reset truncates them at once.
  assign bus.bus_we    = (state_q == StWstrobe);
  assign bus.bus_re    = (state_q == StRreq);
  assign bus.tx_start  = (state_q == StTxgo);
  assign bus.busy      = (state_q != StIdle);
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.cpu_halt  = halt_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_uart_bus_cmd_engine.sv
// Bench for uart_bus_cmd_engine: table vectors, a random command stream checked against a
// transaction-level model, and hand sequences for timeout, saturation and reset corners.
module tb_uart_bus_cmd_engine;
  localparam int unsigned RdLat = 2;
  localparam int unsigned Tmo   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_bus_cmd_engine_if #(.ADDR_W(16)) bif ();
  uart_bus_cmd_engine_if #(.ADDR_W(20)) bif1 ();

  uart_bus_cmd_engine #(.ADDR_W(16), .RD_LAT(RdLat), .TIMEOUT_CYC(Tmo)) dut0 (
    .clk(clk), .rst(rst), .bus(bif.master)
  );
  uart_bus_cmd_engine #(.ADDR_W(20), .RD_LAT(RdLat), .TIMEOUT_CYC(Tmo)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus-side environment: memory with RdLat read latency, write/tx capture.
  logic [7:0]  mem [65536];
  logic        rd_v [RdLat+1];
  logic [7:0]  rd_d [RdLat+1];
  logic [39:0] got_we[$];
  logic [39:0] got_we1[$];
  logic [7:0]  got_tx[$];
  logic [7:0]  td;

  assign bif.bus_rdata  = rd_v[RdLat] ? rd_d[RdLat] : 8'hEE;
  assign bif1.bus_rdata = 8'h00;

  initial begin
    for (int i = 0; i <= RdLat; i++) begin
      rd_v[i] = 1'b0;
      rd_d[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = RdLat; i > 0; i--) begin
        rd_v[i] = rd_v[i-1];
        rd_d[i] = rd_d[i-1];
      end
      rd_v[0] = bif.bus_re;
      rd_d[0] = mem[bif.bus_addr];
      if (bif.bus_we) begin
        mem[bif.bus_addr] = bif.bus_wdata;
        got_we.push_back({16'h0, bif.bus_addr, bif.bus_wdata});
      end
      if (bif1.bus_we) got_we1.push_back({12'h0, bif1.bus_addr, bif1.bus_wdata});
      if (bif.tx_start) got_tx.push_back(bif.tx_data);
    end
  end

  // UART transmitter stand-in: finishes each byte a few cycles after tx_start.
  initial begin
    bif.tx_done  = 1'b0;
    bif1.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.tx_start) begin
        td = bif.tx_data;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 bif.tx_done = 1'b1;
        chk("tx_stable", {24'h0, bif.tx_data}, {24'h0, td});
        @(posedge clk);
        #1 bif.tx_done = 1'b0;
      end
    end
  end

  // Transaction-level reference: what a command list must do to memory and the host.
  logic [7:0]  ref_mem [65536];
  logic [39:0] exp_we[$];
  logic [7:0]  exp_tx[$];
  int          m_err  = 0;
  logic        m_halt = 1'b1;
  logic [7:0]  cq[$];

  task automatic m_err_bump();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_cmd();
    logic [15:0] a;
    logic [15:0] aa;
    int          len;
    a = 16'h0;
    if (cq.size() >= 3) a = {cq[1], cq[2]};
    case (cq[0])
      8'h02: begin
        exp_we.push_back({16'h0, a, cq[3]});
        ref_mem[a] = cq[3];
      end
      8'h03: exp_tx.push_back(ref_mem[a]);
      8'h04: begin
        len = int'(cq[3]) + 1;
        for (int i = 0; i < len; i++) begin
          aa = a + 16'(i);
          exp_we.push_back({16'h0, aa, cq[4+i]});
          ref_mem[aa] = cq[4+i];
        end
      end
      8'h05: begin
        len = int'(cq[3]) + 1;
        for (int i = 0; i < len; i++) begin
          aa = a + 16'(i);
          exp_tx.push_back(ref_mem[aa]);
        end
      end
      8'h06:   m_halt = 1'b1;
      8'h07:   m_halt = 1'b0;
      default: m_err_bump();
    endcase
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    if (sel == 0) begin bif.rx_data = b;  bif.rx_valid = 1'b1;  end
    else          begin bif1.rx_data = b; bif1.rx_valid = 1'b1; end
    @(posedge clk);
    #1;
    bif.rx_valid  = 1'b0;
    bif1.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bif.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bif.busy) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  task automatic clear_q();
    got_we.delete();
    got_tx.delete();
    exp_we.delete();
    exp_tx.delete();
  endtask

  task automatic compare_q(input string name);
    chk({name, "_nwe"}, got_we.size(), exp_we.size());
    for (int i = 0; i < got_we.size() && i < exp_we.size(); i++)
      chk({name, "_we"}, got_we[i], exp_we[i]);
    chk({name, "_ntx"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      chk({name, "_tx"}, {24'h0, got_tx[i]}, {24'h0, exp_tx[i]});
    chk({name, "_err"}, {24'h0, bif.err_count}, m_err);
    chk({name, "_halt"}, {31'h0, bif.cpu_halt}, {31'h0, m_halt});
  endtask

  // gap < 0 picks a random inter-byte gap.
  task automatic run_cmd(input string name, input int gap);
    clear_q();
    model_cmd();
    foreach (cq[i]) send_byte(0, cq[i], (gap < 0) ? $urandom_range(2, 4) : gap);
    wait_idle(name);
    compare_q(name);
  endtask

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    int              n_we;
    logic [15:0]     we_a0;
    logic [7:0]      we_d0;
    logic [15:0]     we_a1;
    logic [7:0]      we_d1;
    int              n_tx;
    logic [7:0]      tx0;
    logic [7:0]      tx1;
    int              err;
    logic            halt;
  } vec_t;

  vec_t v [10];

  initial begin
    // bytes, n, n_we, first addr/data, last addr/data, n_tx, first/last tx, err, halt
    v[0] = '{64'h06_00000000000000, 1, 0, 16'h0,    8'h0,  16'h0,    8'h0,  0, 8'h0,  8'h0,  0, 1};
    v[1] = '{64'h02_8010A5_00000000, 4, 1, 16'h8010, 8'hA5, 16'h8010, 8'hA5, 0, 8'h0, 8'h0, 0, 1};
    v[2] = '{64'h03_8010_0000000000, 3, 0, 16'h0,    8'h0,  16'h0,    8'h0,  1, 8'hA5, 8'hA5, 0, 1};
    v[3] = '{64'h04_00FE03_11223344, 8, 4, 16'h00FE, 8'h11, 16'h0101, 8'h44, 0, 8'h0, 8'h0, 0, 1};
    v[4] = '{64'h05_00FE03_00000000, 4, 0, 16'h0,    8'h0,  16'h0,    8'h0,  4, 8'h11, 8'h44, 0, 1};
    v[5] = '{64'h04_FFFF01_AABB0000, 6, 2, 16'hFFFF, 8'hAA, 16'h0000, 8'hBB, 0, 8'h0, 8'h0, 0, 1};
    v[6] = '{64'h05_FFFF01_00000000, 4, 0, 16'h0,    8'h0,  16'h0,    8'h0,  2, 8'hAA, 8'hBB, 0, 1};
    v[7] = '{64'h09_00000000000000, 1, 0, 16'h0,    8'h0,  16'h0,    8'h0,  0, 8'h0,  8'h0,  1, 1};
    v[8] = '{64'h07_00000000000000, 1, 0, 16'h0,    8'h0,  16'h0,    8'h0,  0, 8'h0,  8'h0,  1, 0};
    v[9] = '{64'h06_00000000000000, 1, 0, 16'h0,    8'h0,  16'h0,    8'h0,  0, 8'h0,  8'h0,  1, 1};

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    end
    bif.rx_valid  = 1'b0;
    bif.rx_data   = 8'h00;
    bif1.rx_valid = 1'b0;
    bif1.rx_data  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", {31'h0, bif.tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, bif.tx_data}, 32'h0);
    chk("rst_bus_addr", {16'h0, bif.bus_addr}, 32'h0);
    chk("rst_bus_wdata", {24'h0, bif.bus_wdata}, 32'h0);
    chk("rst_strobes", {30'h0, bif.bus_we, bif.bus_re}, 32'h0);
    chk("rst_busy", {31'h0, bif.busy}, 32'h0);
    chk("rst_err", {24'h0, bif.err_count}, 32'h0);
    chk("rst_halt", {31'h0, bif.cpu_halt}, 32'h1);
    chk("rst_halt1", {31'h0, bif1.cpu_halt}, 32'h1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 10; k++) begin
      cq.delete();
      for (int i = 0; i < v[k].n; i++) cq.push_back(v[k].b[i]);
      run_cmd("vec", -1);
      chk("vec_nwe", got_we.size(), v[k].n_we);
      if (got_we.size() > 0 && v[k].n_we > 0) begin
        chk("vec_we_first", got_we[0], {16'h0, v[k].we_a0, v[k].we_d0});
        chk("vec_we_last", got_we[got_we.size()-1], {16'h0, v[k].we_a1, v[k].we_d1});
      end
      chk("vec_ntx", got_tx.size(), v[k].n_tx);
      if (got_tx.size() > 0 && v[k].n_tx > 0) begin
        chk("vec_tx_first", {24'h0, got_tx[0]}, {24'h0, v[k].tx0});
        chk("vec_tx_last", {24'h0, got_tx[got_tx.size()-1]}, {24'h0, v[k].tx1});
      end
      chk("vec_err", {24'h0, bif.err_count}, v[k].err);
      chk("vec_halt", {31'h0, bif.cpu_halt}, {31'h0, v[k].halt});
    end

    // busy must drop the cycle after tx_done.
    clear_q();
    cq.delete();
    cq.push_back(8'h03); cq.push_back(8'h80); cq.push_back(8'h10);
    model_cmd();
    foreach (cq[i]) send_byte(0, cq[i], 2);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bif.tx_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("rd_tx_done_seen", {31'h0, bif.tx_done}, 32'h1);
      chk("rd_busy_at_done", {31'h0, bif.busy}, 32'h1);
      @(negedge clk);
      chk("rd_busy_after_done", {31'h0, bif.busy}, 32'h0);
    end
    compare_q("rd_single");

    // Halt/release take effect the cycle after the strobe.
    send_byte(0, 8'h07, 0);
    chk("release_next_cycle", {31'h0, bif.cpu_halt}, 32'h0);
    send_byte(0, 8'h06, 0);
    chk("halt_next_cycle", {31'h0, bif.cpu_halt}, 32'h1);

    for (int k = 0; k < 60; k++) begin
      int          r;
      logic [15:0] a;
      logic [7:0]  j;
      int          len;
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? {12'h0, 4'($urandom)} : 16'($urandom);
      if (r == 9) a = 16'hFFFE;
      len = $urandom_range(0, 6);
      cq.delete();
      case (r)
        0, 1: begin
          cq.push_back(8'h02); cq.push_back(a[15:8]); cq.push_back(a[7:0]);
          cq.push_back(8'($urandom));
        end
        2, 3: begin
          cq.push_back(8'h03); cq.push_back(a[15:8]); cq.push_back(a[7:0]);
        end
        4: begin
          cq.push_back(8'h04); cq.push_back(a[15:8]); cq.push_back(a[7:0]);
          cq.push_back(8'(len));
          for (int i = 0; i <= len; i++) cq.push_back(8'($urandom));
        end
        5, 9: begin
          cq.push_back(8'h05); cq.push_back(a[15:8]); cq.push_back(a[7:0]);
          cq.push_back(8'(len));
        end
        6: cq.push_back(8'h06);
        7: cq.push_back(8'h07);
        default: begin
          j = 8'($urandom_range(8, 255));
          cq.push_back(j);
        end
      endcase
      run_cmd("rand", -1);
    end

    // Byte arriving during a burst read is dropped and counted; the burst completes.
    clear_q();
    cq.delete();
    cq.push_back(8'h05); cq.push_back(8'h00); cq.push_back(8'hFE); cq.push_back(8'h03);
    model_cmd();
    m_err_bump();
    foreach (cq[i]) send_byte(0, cq[i], 2);
    send_byte(0, 8'h99, 2);
    wait_idle("drop");
    compare_q("drop");

    // Gaps just under the timeout keep the command alive.
    cq.delete();
    cq.push_back(8'h02); cq.push_back(8'h12); cq.push_back(8'h34); cq.push_back(8'h5A);
    run_cmd("near_tmo", Tmo - 2);

    // Silence after a partial address aborts without a bus strobe.
    clear_q();
    send_byte(0, 8'h02, 2);
    send_byte(0, 8'h12, Tmo + 5);
    m_err_bump();
    chk("tmo_idle", {31'h0, bif.busy}, 32'h0);
    chk("tmo_no_we", got_we.size(), 0);
    chk("tmo_err", {24'h0, bif.err_count}, m_err);
    send_byte(0, 8'h55, 2);
    m_err_bump();
    chk("tmo_junk_err", {24'h0, bif.err_count}, m_err);

    // Error counter saturates.
    for (int i = 0; i < 260; i++) send_byte(0, 8'hFF, 0);
    for (int i = 0; i < 260; i++) m_err_bump();
    chk("err_saturate", {24'h0, bif.err_count}, 32'hFF);
    send_byte(0, 8'h01, 1);
    chk("err_stays_sat", {24'h0, bif.err_count}, 32'hFF);

    // Wider address: three address bytes, upper bits beyond 20 ignored.
    got_we1.delete();
    send_byte(1, 8'h02, 2);
    send_byte(1, 8'h01, 2);
    send_byte(1, 8'h23, 2);
    send_byte(1, 8'h45, 2);
    send_byte(1, 8'h7E, 4);
    chk("aw20_nwe", got_we1.size(), 1);
    if (got_we1.size() > 0) chk("aw20_we", got_we1[0], {12'h0, 20'h12345, 8'h7E});
    chk("aw20_busy", {31'h0, bif1.busy}, 32'h0);
    send_byte(1, 8'h07, 0);
    chk("aw20_release", {31'h0, bif1.cpu_halt}, 32'h0);

    // Async reset in the middle of a write strobe.
    send_byte(0, 8'h07, 2);
    send_byte(0, 8'h04, 2);
    send_byte(0, 8'h00, 2);
    send_byte(0, 8'h10, 2);
    send_byte(0, 8'h01, 2);
    send_byte(0, 8'hAA, 0);
    chk("mid_we_high", {31'h0, bif.bus_we}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'h0, bif.bus_we}, 32'h0);
    chk("mid_rst_busy", {31'h0, bif.busy}, 32'h0);
    chk("mid_rst_halt", {31'h0, bif.cpu_halt}, 32'h1);
    chk("mid_rst_addr", {16'h0, bif.bus_addr}, 32'h0);
    chk("mid_rst_err", {24'h0, bif.err_count}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
